// File: rtl/ft245_tx_arbiter.sv
// ft245_tx_arbiter: round-robin arbiter of four byte requesters onto one FT245 TX port,
// optionally prefixing each grant with a channel header byte and capping grants at MAX_BURST bytes.
`ifndef FT245_WIDTH
`define FT245_WIDTH 8
`endif
module ft245_tx_arbiter #(
  parameter int FT245_WIDTH = `FT245_WIDTH,
  parameter int MAX_BURST = 64,
  parameter bit HEADER_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4*FT245_WIDTH-1:0] req_data,
  input  logic [3:0]               req_rdy,
  input  logic [3:0]               req_last,
  output logic [3:0]               req_ack,
  output logic [FT245_WIDTH-1:0]   tx_data_si,
  output logic                     tx_rdy_si,
  input  logic                     tx_ack_si,
  output logic [3:0]               grant,
  output logic                     busy,
  output logic                     trunc
);
  localparam int CW = $clog2(MAX_BURST);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state;
  logic [1:0] idx, last_idx, pick;
  logic [CW-1:0] cnt;
  logic in_data, xfer;
  // scan downward so the requester closest after last_idx is the one that sticks
  always_comb begin
    pick = last_idx;
    for (int k = 4; k >= 1; k--)
      if (req_rdy[2'(last_idx + 2'(k))]) pick = 2'(last_idx + 2'(k));
  end
  assign in_data = state == DATA;
  assign busy = state != IDLE;
  assign grant = busy ? 4'b0001 << idx : 4'd0;
  assign tx_rdy_si = state == HDR || (in_data && req_rdy[idx]);
  assign tx_data_si = state == HDR ? FT245_WIDTH'({4'hA, 2'b00, idx}) :
                      in_data ? req_data[idx*FT245_WIDTH +: FT245_WIDTH] : '0;
  assign xfer = in_data && req_rdy[idx] && tx_ack_si;
  assign req_ack = xfer ? 4'b0001 << idx : 4'd0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      last_idx <= 2'd3;
      cnt <= '0;
      trunc <= 1'b0;
    end else begin
      trunc <= 1'b0;
      case (state)
        IDLE: if (|req_rdy) begin
          idx <= pick;
          cnt <= '0;
          state <= HEADER_EN ? HDR : DATA;
        end
        HDR: if (tx_ack_si) begin
          cnt <= '0;
          state <= DATA;
        end
        DATA: if (xfer) begin
          cnt <= cnt + 1'b1;
          if (req_last[idx] || cnt == CW'(MAX_BURST - 1)) begin
            state <= IDLE;
            last_idx <= idx;
            trunc <= !req_last[idx];
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
